// File: rtl/shift_reg_n.sv
// Parametrised DEPTH x WIDTH register chain: hold, shift up/down, parallel load, saturating fill count.
// Optional macro SHIFT_REG_N_ROTATE_EN adds port ROT for rotate-up/down in the shift modes.
module shift_reg_n #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic                   CK,
  input  logic                   RST,
  input  logic                   EN,
  input  logic                   CLR,
  input  logic [1:0]             MODE,
  input  logic [WIDTH-1:0]       SIN,
`ifdef SHIFT_REG_N_ROTATE_EN
  input  logic                   ROT,
`endif
  input  logic [DEPTH*WIDTH-1:0] PIN,
  output logic [DEPTH*WIDTH-1:0] POUT,
  output logic [WIDTH-1:0]       SOUT_UP,
  output logic [WIDTH-1:0]       SOUT_DN,
  output logic [CW-1:0]          COUNT,
  output logic                   FULL
);

  localparam int unsigned TW = DEPTH * WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DN   = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [TW-1:0] data_q, data_d;
  logic [CW-1:0] count_q, count_d;
  logic          rot;
  logic [CW-1:0] count_inc;

`ifdef SHIFT_REG_N_ROTATE_EN
  assign rot = ROT;
`else
  assign rot = 1'b0;
`endif

  assign count_inc = (count_q == DEPTH_C) ? count_q : count_q + CW'(1);

  // Next state: CLR beats EN, EN low holds, otherwise MODE selects the operation.
  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    if (CLR) begin
      data_d  = '0;
      count_d = '0;
    end else if (EN) begin
      case (MODE)
        MODE_HOLD: begin
          data_d  = data_q;
          count_d = count_q;
        end
        MODE_UP: begin
          data_d  = {data_q[TW-WIDTH-1:0], (rot ? data_q[TW-1 -: WIDTH] : SIN)};
          count_d = rot ? count_q : count_inc;
        end
        MODE_DN: begin
          data_d  = {(rot ? data_q[WIDTH-1:0] : SIN), data_q[TW-1:WIDTH]};
          count_d = rot ? count_q : count_inc;
        end
        MODE_LOAD: begin
          data_d  = PIN;
          count_d = DEPTH_C;
        end
        default: begin
          data_d  = data_q;
          count_d = count_q;
        end
      endcase
    end
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      data_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  // Outputs are straight decodes of the state registers.
  assign POUT    = data_q;
  assign SOUT_UP = data_q[TW-1 -: WIDTH];
  assign SOUT_DN = data_q[WIDTH-1:0];
  assign COUNT   = count_q;
  assign FULL    = (count_q == DEPTH_C);

endmodule

// File: tb/tb_shift_reg_n.sv
// Scoreboard bench for shift_reg_n (WIDTH=4, DEPTH=4): directed hand-checked vectors then random vs. model.
module tb_shift_reg_n;

  logic        CK;
  logic        RST;
  logic        EN;
  logic        CLR;
  logic [1:0]  MODE;
  logic [3:0]  SIN;
`ifdef SHIFT_REG_N_ROTATE_EN
  logic        ROT;
`endif
  logic [15:0] PIN;
  logic [15:0] POUT;
  logic [3:0]  SOUT_UP;
  logic [3:0]  SOUT_DN;
  logic [2:0]  COUNT;
  logic        FULL;

  shift_reg_n #(.WIDTH(4), .DEPTH(4), .CW(3)) dut (
    .CK(CK), .RST(RST), .EN(EN), .CLR(CLR), .MODE(MODE), .SIN(SIN),
`ifdef SHIFT_REG_N_ROTATE_EN
    .ROT(ROT),
`endif
    .PIN(PIN), .POUT(POUT), .SOUT_UP(SOUT_UP), .SOUT_DN(SOUT_DN),
    .COUNT(COUNT), .FULL(FULL)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  typedef struct {
    string       tag;
    logic [15:0] pout;
    logic [2:0]  count;
    logic        full;
    logic [3:0]  up;
    logic [3:0]  dn;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  event rst_ev;

  // Behavioural reference used for the random phase.
  logic [3:0] ms[4];
  int         mcount;

  function automatic exp_t hand_exp(input string tag, input logic [15:0] p, input int c);
    exp_t e;
    e.tag   = tag;
    e.pout  = p;
    e.count = 3'(c);
    e.full  = (c == 4);
    e.up    = p[15:12];
    e.dn    = p[3:0];
    return e;
  endfunction

  function automatic exp_t model_exp(input string tag);
    return hand_exp(tag, {ms[3], ms[2], ms[1], ms[0]}, mcount);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) ms[k] = 4'h0;
    mcount = 0;
  endtask

  task automatic model_edge(input logic en, input logic clr, input logic [1:0] mode,
                            input logic [3:0] sin, input logic [15:0] pin, input logic rot);
    logic [3:0] t;
    if (clr) begin
      model_reset();
    end else if (en) begin
      case (mode)
        2'b01: begin
          t = rot ? ms[3] : sin;
          for (int k = 3; k > 0; k--) ms[k] = ms[k-1];
          ms[0] = t;
          if (!rot && mcount < 4) mcount++;
        end
        2'b10: begin
          t = rot ? ms[0] : sin;
          for (int k = 0; k < 3; k++) ms[k] = ms[k+1];
          ms[3] = t;
          if (!rot && mcount < 4) mcount++;
        end
        2'b11: begin
          for (int k = 0; k < 4; k++) ms[k] = pin[k*4 +: 4];
          mcount = 4;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_one();
    exp_t e;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    checks++;
    if (POUT !== e.pout || COUNT !== e.count || FULL !== e.full ||
        SOUT_UP !== e.up || SOUT_DN !== e.dn) begin
      errors++;
      $display("FAIL %s: got POUT=%h COUNT=%0d FULL=%b SOUT_UP=%h SOUT_DN=%h, want POUT=%h COUNT=%0d FULL=%b SOUT_UP=%h SOUT_DN=%h",
               e.tag, POUT, COUNT, FULL, SOUT_UP, SOUT_DN, e.pout, e.count, e.full, e.up, e.dn);
    end
  endtask

  // Monitor: edge results one time unit after each posedge, async reset results on request.
  always @(posedge CK) begin
    #1;
    check_one();
  end

  always @(rst_ev) begin
    #1;
    check_one();
  end

  // One clock of stimulus; hand=1 pushes the given constants, else the model's prediction.
  task automatic step(input string tag, input logic en, input logic clr, input logic [1:0] mode,
                      input logic [3:0] sin, input logic [15:0] pin, input logic rot,
                      input logic pulse_rst, input bit hand,
                      input logic [15:0] exp_pout, input int exp_cnt);
    @(negedge CK);
    EN = en; CLR = clr; MODE = mode; SIN = sin; PIN = pin;
`ifdef SHIFT_REG_N_ROTATE_EN
    ROT = rot;
`endif
    if (pulse_rst) begin
      #1 RST = 1'b1;
      model_reset();
      exp_q.push_back(hand_exp({tag, "_async_rst"}, 16'h0000, 0));
      -> rst_ev;
      #2 RST = 1'b0;
    end
    @(posedge CK);
    model_edge(en, clr, mode, sin, pin, rot);
    if (hand) exp_q.push_back(hand_exp(tag, exp_pout, exp_cnt));
    else      exp_q.push_back(model_exp(tag));
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; CLR = 1'b0; MODE = 2'b00; SIN = '0; PIN = '0;
`ifdef SHIFT_REG_N_ROTATE_EN
    ROT = 1'b0;
`endif
    model_reset();
    #3;
    exp_q.push_back(hand_exp("power_on_rst", 16'h0000, 0));
    -> rst_ev;
    #4 RST = 1'b0;

    // Reset asserted mid-shift, then first edge after release
    step("up_3",      1, 0, 2'b01, 4'h3, 16'h0, 0, 0, 1, 16'h0003, 1);
    step("up_7",      1, 0, 2'b01, 4'h7, 16'h0, 0, 0, 1, 16'h0037, 2);
    step("rst_up_A",  1, 0, 2'b01, 4'hA, 16'h0, 0, 1, 1, 16'h000A, 1);

    // Shift up into saturation
    step("clr",       1, 1, 2'b00, 4'h0, 16'h0, 0, 0, 1, 16'h0000, 0);
    step("up_1",      1, 0, 2'b01, 4'h1, 16'h0, 0, 0, 1, 16'h0001, 1);
    step("up_2",      1, 0, 2'b01, 4'h2, 16'h0, 0, 0, 1, 16'h0012, 2);
    step("up_3b",     1, 0, 2'b01, 4'h3, 16'h0, 0, 0, 1, 16'h0123, 3);
    step("up_4_full", 1, 0, 2'b01, 4'h4, 16'h0, 0, 0, 1, 16'h1234, 4);
    step("up_5_sat",  1, 0, 2'b01, 4'h5, 16'h0, 0, 0, 1, 16'h2345, 4);

    // Load then shift down
    step("load_DCBA", 1, 0, 2'b11, 4'h0, 16'hDCBA, 0, 0, 1, 16'hDCBA, 4);
    step("dn_E",      1, 0, 2'b10, 4'hE, 16'h0,    0, 0, 1, 16'hEDCB, 4);

    // Priority: EN=0 holds, CLR beats MODE
    step("load_1234", 1, 0, 2'b11, 4'h0, 16'h1234, 0, 0, 1, 16'h1234, 4);
    step("en0_hold",  0, 0, 2'b11, 4'h0, 16'hFFFF, 0, 0, 1, 16'h1234, 4);
    step("clr_prio",  1, 1, 2'b01, 4'h5, 16'hFFFF, 0, 0, 1, 16'h0000, 0);
    step("dn_9",      1, 0, 2'b10, 4'h9, 16'h0,    0, 0, 1, 16'h9000, 1);
    step("hold",      1, 0, 2'b00, 4'h6, 16'hFFFF, 0, 0, 1, 16'h9000, 1);

`ifdef SHIFT_REG_N_ROTATE_EN
    step("rload_1234", 1, 0, 2'b11, 4'h0, 16'h1234, 1, 0, 1, 16'h1234, 4);
    step("rot_up",     1, 0, 2'b01, 4'hF, 16'h0,    1, 0, 1, 16'h2341, 4);
    step("rot_dn",     1, 0, 2'b10, 4'hF, 16'h0,    1, 0, 1, 16'h1234, 4);
    step("rclr",       1, 1, 2'b00, 4'h0, 16'h0,    0, 0, 1, 16'h0000, 0);
    step("rup_5",      1, 0, 2'b01, 4'h5, 16'h0,    0, 0, 1, 16'h0005, 1);
    step("rot_up_cnt", 1, 0, 2'b01, 4'hF, 16'h0,    1, 0, 1, 16'h0050, 1);
`endif

    // Random phase against the model with three async reset pulses
    for (int i = 0; i < 500; i++) begin
      logic r_en, r_clr, r_rot, r_rst;
      logic [1:0]  r_mode;
      logic [3:0]  r_sin;
      logic [15:0] r_pin;
      r_en   = ($urandom_range(0, 9) != 0);
      r_clr  = ($urandom_range(0, 19) == 0);
      r_mode = 2'($urandom_range(0, 3));
      r_sin  = 4'($urandom);
      r_pin  = 16'($urandom);
`ifdef SHIFT_REG_N_ROTATE_EN
      r_rot  = 1'($urandom_range(0, 1));
`else
      r_rot  = 1'b0;
`endif
      r_rst  = (i == 100 || i == 250 || i == 400);
      step("rand", r_en, r_clr, r_mode, r_sin, r_pin, r_rot, r_rst, 0, 16'h0, 0);
    end

    repeat (3) @(posedge CK);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected results never checked, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
